// File: rtl/csa_pkg.sv
// Shared types and width helpers for the carry-save stream accumulator.
// Widths derive from operand width and the per-transaction operand limit.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int acc_width(input int width, input int max_ops);
        return width + $clog2(max_ops);
    endfunction

    function automatic int cnt_width(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// Vector 3:2 carry-save compressor, one full adder per bit; purely combinational.
// Majority output is unshifted; the caller aligns it as a carry vector.
module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] maj_o
);

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c_i[i];
        assign maj_o[i] = (a_i[i] & b_i[i]) | (a_i[i] & c_i[i]) | (b_i[i] & c_i[i]);
    end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Reduces an operand stream to one sum in carry-save form; result 2+k cycles after last operand.
// Input stalls (in_ready=0) while resolving or holding a result; result held until out_ready.
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 16,
    parameter int ACC_W   = acc_width(WIDTH, MAX_OPS),
    parameter int CNT_W   = cnt_width(MAX_OPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OPS);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d, c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] data_ext, csa_z, csa_sum, csa_maj;

    assign data_ext = ACC_W'(in_data);
    // Third compressor input is the new operand while accumulating, zero while resolving.
    assign csa_z    = (state_q == ACCUM) ? data_ext : '0;

    csa_3to2 #(.W(ACC_W)) u_csa (
        .a_i   (s_q),
        .b_i   (c_q),
        .c_i   (csa_z),
        .sum_o (csa_sum),
        .maj_o (csa_maj)
    );

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d     = data_ext;
                    c_d     = '0;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    s_d = csa_sum;
                    c_d = csa_maj << 1;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                if (c_q == '0) begin
                    state_d = DONE;
                end else begin
                    s_d = csa_sum;
                    c_d = csa_maj << 1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = s_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed and randomized checks of the carry-save stream accumulator against
// a plain-arithmetic model of the accepted operand stream.
module tb_csa_accum_ctrl;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 16;
    localparam int ACC_W   = 8;
    localparam int CNT_W   = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    int ops_q[$];

    csa_accum_ctrl #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one operand and wait (bounded) until it is accepted.
    task automatic send_op(input int d, input logic last);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_last  = last;
        for (int t = 0; t < 60 && !done; t++) begin
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic feed();
        foreach (ops_q[i]) send_op(ops_q[i], i == ops_q.size() - 1);
    endtask

    // Edges from (and including) the last accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag);
        int sum;
        int n;
        sum = 0;
        n   = ops_q.size();
        foreach (ops_q[i]) sum += ops_q[i];
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(out_sum),   32'(sum % 256));
        chk({tag, "_count"}, 32'(out_count), 32'((n > MAX_OPS) ? MAX_OPS : n));
        chk({tag, "_ovf"},   32'(out_ovf),   32'(n > MAX_OPS));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_busy"},  32'(busy),      32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int held_sum;
        int held_cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single operand: result two edges after the accept.
        ops_q = '{15};
        feed();
        wait_done(lat);
        chk("t1_latency", 32'(lat), 32'd2);
        check_result("t1");
        release_out("t1");

        ops_q = '{3, 5, 7, 9};
        feed();
        wait_done(lat);
        check_result("t2");
        release_out("t2");

        ops_q = {};
        repeat (16) ops_q.push_back(15);
        feed();
        wait_done(lat);
        check_result("t3a");
        release_out("t3a");

        ops_q = {};
        repeat (18) ops_q.push_back(15);
        feed();
        wait_done(lat);
        check_result("t3b");
        release_out("t3b");

        ops_q = '{1, 15, 15, 15, 15};
        feed();
        wait_done(lat);
        chk("t4_latency_bound", 32'(lat <= ACC_W + 2), 32'd1);
        check_result("t4");
        release_out("t4");

        // Result held under backpressure while a new operand is pushed.
        ops_q = '{2, 3};
        feed();
        wait_done(lat);
        check_result("t5");
        held_sum = int'(out_sum);
        held_cnt = int'(out_count);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'd6;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_sum",   32'(out_sum),   32'(held_sum));
            chk("t5_hold_count", 32'(out_count), 32'(held_cnt));
            chk("t5_hold_ready", 32'(in_ready),  32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rel_valid", 32'(out_valid), 32'd0);
        chk("t5_rel_ready", 32'(in_ready),  32'd1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ops_q = '{6};
        wait_done(lat);
        check_result("t5_pushed");
        release_out("t5_pushed");

        // Asynchronous reset in the middle of accumulation.
        send_op(2, 1'b0);
        send_op(4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_sum",   32'(out_sum),   32'd0);
        chk("t6_rst_count", 32'(out_count), 32'd0);
        chk("t6_rst_ovf",   32'(out_ovf),   32'd0);
        chk("t6_rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ops_q = '{1, 2};
        feed();
        wait_done(lat);
        check_result("t6");
        release_out("t6");

        // Randomized transactions, including over-length ones.
        for (int t = 0; t < 1000; t++) begin
            int n;
            n = int'($urandom_range(1, 20));
            ops_q = {};
            for (int i = 0; i < n; i++) ops_q.push_back(int'($urandom_range(0, 15)));
            feed();
            wait_done(lat);
            chk("rnd_latency_bound", 32'(lat <= ACC_W + 2), 32'd1);
            check_result("rnd");
            repeat ($urandom_range(0, 2)) @(posedge clk);
            release_out("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
